// File: rtl/sound_i2s_tx.sv
// sound_i2s_tx: stereo I2S transmitter for the ABC80 sound path.
//
// Sample pairs enter through a small FIFO. One left/right pair is
// serialized per frame of 2*SLOT_W bit clocks, MSB first, and the
// per-frame strobe paces the sound generators.
//
// Ports:
//   clk        bit clock and system clock
//   rst_n      asynchronous active-low reset
//   s_valid    sample pair offered
//   s_ready    FIFO can accept a pair
//   s_left     left sample
//   s_right    right sample
//   mute       force transmitted data to zero (sampled at frame boundary)
//   i2s_dat    serial data, MSB first
//   i2s_lrck   word select: 0 = left slot, 1 = right slot
//   frame_stb  one-cycle pulse on the last clock of each frame
//   underrun   pulse with frame_stb when the FIFO was empty at the boundary
//
// Handshake: a pair is transferred on every rising clk edge where
// s_valid and s_ready are both high. s_ready depends only on the
// registered FIFO count, never on s_valid; s_valid may be raised or
// dropped freely, and the offered data is only consumed when accepted.

module sound_i2s_tx #(
  parameter int SAMPLE_W      = 14,
  parameter int SLOT_W        = 128,
  parameter int FIFO_DEPTH    = 4,
  parameter int SIGNED_IN     = 0,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                mute,
  output logic                i2s_dat,
  output logic                i2s_lrck,
  output logic                frame_stb,
  output logic                underrun
);

  localparam int CW   = $clog2(2 * SLOT_W);
  localparam int PW   = CW - 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  // Zero bits ahead of the sample in each slot: the I2S one-bit delay,
  // plus a 0 sign bit when the input is unsigned.
  localparam int LEAD = (SIGNED_IN != 0) ? 1 : 2;

  localparam logic [CW-1:0] CTR_LAST = CW'(2 * SLOT_W - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

  logic [CW-1:0]       ctr;
  logic [PW-1:0]       pos;
  logic [AW:0]         count;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [SAMPLE_W-1:0] mem_left  [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_right [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] held_left;
  logic [SAMPLE_W-1:0] held_right;
  logic                mute_q;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [SLOT_W-1:0]   slot_word;

  // Everything below is decoded from registered state only.
  assign fifo_empty = (count == '0);
  assign s_ready    = (count != FULL);
  assign frame_stb  = (ctr == CTR_LAST);
  assign underrun   = frame_stb & fifo_empty;
  assign push       = s_valid & s_ready;
  assign pop        = frame_stb & ~fifo_empty;

  assign pos      = ctr[PW-1:0];
  assign i2s_lrck = ctr[CW-1];

  // Free-running frame counter; wraps naturally since 2*SLOT_W is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + CW'(1);
    end
  end

  // FIFO storage needs no reset: it is only read when count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_left[wr_ptr]  <= s_left;
      mem_right[wr_ptr] <= s_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame-boundary update: load the next pair (or apply the underrun
  // policy) and latch mute so it covers exactly one whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_left  <= '0;
      held_right <= '0;
      mute_q     <= 1'b0;
    end else if (frame_stb) begin
      if (pop) begin
        held_left  <= mem_left[rd_ptr];
        held_right <= mem_right[rd_ptr];
      end else if (UNDERRUN_HOLD == 0) begin
        held_left  <= '0;
        held_right <= '0;
      end
      mute_q <= mute;
    end
  end

  // Slot word: leading zeros, sample, then zero padding to SLOT_W bits.
  always_comb begin
    slot_word = '0;
    slot_word[SLOT_W-1-LEAD -: SAMPLE_W] = i2s_lrck ? held_right : held_left;
  end

  // Bit SLOT_W-1-pos equals ~pos because SLOT_W is a power of two.
  assign i2s_dat = ~mute_q & slot_word[~pos];

endmodule

// File: doc/sound_i2s_tx.md
# sound_i2s_tx

Parametrised stereo I2S transmitter for the ABC80 sound path. It replaces the fixed 14-bit, mono-only serializer. Sample pairs from one or more sound generators or a mixer are accepted through a valid/ready handshake into a small FIFO. The block serializes one left/right pair per frame and emits the per-frame strobe that paces the sound generators (the 16 µs strobe at 16 MHz with default parameters). It also reports FIFO underrun and supports mute.

## Interface
Parameters:
- SAMPLE_W, 14: sample width in bits, unsigned or two's complement per SIGNED_IN; SAMPLE_W + 2 <= SLOT_W.
- SLOT_W, 128: bit clocks per channel slot; power of two, >= 4; frame = 2*SLOT_W clocks.
- FIFO_DEPTH, 4: sample-pair FIFO entries; power of two, >= 2.
- SIGNED_IN, 0: 0 = unsigned input, a 0 sign bit is prepended; 1 = input already signed, no extra bit.
- UNDERRUN_HOLD, 1: on underrun, 1 = repeat the last pair, 0 = send zeros.

Ports:
- clk  in  1  bit clock and system clock (16 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  FIFO can accept a pair.
- s_left  in  SAMPLE_W  left sample.
- s_right  in  SAMPLE_W  right sample.
- mute  in  1  force transmitted data to zero.
- i2s_dat  out  1  serial data, MSB first.
- i2s_lrck  out  1  word select: 0 = left slot, 1 = right slot.
- frame_stb  out  1  one-cycle pulse on the last clock of each frame.
- underrun  out  1  one-cycle pulse, coincident with frame_stb, when the FIFO was empty at the frame boundary.

## Operation
- Frame counter ctr: log2(2*SLOT_W) bits, free-running, wraps 2*SLOT_W-1 -> 0. Slot position p = ctr mod SLOT_W. i2s_lrck = ctr MSB.
- Slot word W, SLOT_W bits, MSB transmitted first:
  - SIGNED_IN=0: W = {1'b0, 1'b0, sample, zeros}.
  - SIGNED_IN=1: W = {1'b0, sample, zeros}.
  - The leading 0 is the I2S one-bit delay.
- At position p of a slot, i2s_dat = W[SLOT_W-1-p]. The left slot uses held_left; the right slot uses held_right.
- Frame boundary is the cycle with ctr = 2*SLOT_W-1 (frame_stb high). On that cycle:
  - FIFO non-empty: pop the head into held_left/held_right.
  - FIFO empty: assert underrun. held_* keep their value if UNDERRUN_HOLD=1, otherwise load 0.
  - Sample mute into mute_q.
- Mute: mute_q=1 forces W = 0 for the whole next frame. The FIFO still pops one pair per frame.
- A pair popped at the end of frame k is transmitted in frame k+1.
- FIFO:
  - Push when s_valid & s_ready.
  - s_ready = (count != FIFO_DEPTH), driven from a registered count.
  - Push and pop in the same cycle leave count unchanged.
  - A push while full is impossible because s_ready is low. The FIFO does not accept a push on the same cycle a full FIFO pops; s_ready rises on the following cycle.
  - Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous, any cycle):
  - Outputs: i2s_dat=0, i2s_lrck=0, frame_stb=0, underrun=0, s_ready=1 (also while reset is held).
  - Internal: ctr=0, FIFO empty, held_*=0, mute_q=0.
  - Counting resumes from 0 on the first clock after rst_n rises.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from s_valid, s_left, s_right or mute to any output.
- frame_stb period is exactly 2*SLOT_W clocks. The first frame_stb occurs 2*SLOT_W-1 clocks after reset release.
- Minimum latency from an accepted push (empty FIFO) to the first data bit on i2s_dat:
  - Wait for the next frame boundary.
  - Then 1 clock (SIGNED_IN=1) or 2 clocks (SIGNED_IN=0) into the left slot.
- i2s_dat changes only on rising clk edges. i2s_lrck toggles at p = 0 of each slot.
- mute changes take effect only at a frame boundary. There are never partial-frame glitches.

## Test plan
- Idle after reset, defaults:
  - i2s_dat stays 0.
  - i2s_lrck toggles every 128 clocks.
  - frame_stb and underrun pulse together every 256 clocks; the first pulse is at clock 255.
- Push L=14'h2AAA, R=14'h1555 mid-frame, defaults:
  - Next frame left slot: p0..1 = 0, p2..15 = 10101010101010, p16..127 = 0.
  - Right slot: p2..15 = 01010101010101.
  - No underrun on that boundary.
- Overfill, s_valid held with 5 distinct pairs:
  - s_ready drops after 4 accepts and rises 1 clock after the next frame_stb.
  - Pairs are transmitted in push order, one per frame.
- Underrun policy, one pair pushed then none:
  - UNDERRUN_HOLD=1: the pair repeats every subsequent frame, with underrun pulsing.
  - UNDERRUN_HOLD=0: zeros are sent after the first frame.
- Mute: 3 pairs queued, mute=1 asserted mid-frame:
  - From the next frame, i2s_dat=0 for 3 frames while count goes 3->2->1->0.
  - Deasserting mute resumes data at the following boundary.
- Async reset at ctr=60 with 2 pairs queued:
  - Outputs go to reset values without a clock.
  - After release, the FIFO is empty, ctr restarts at 0, and frame_stb occurs at clock 255.
